// File: rtl/map_pixel_gen_pkg.sv
// Shared display definitions: tile encoding, palette, XVGA timing constants.
package map_pixel_gen_pkg;

  typedef enum logic [1:0] {
    SKY  = 2'd0,
    ROCK = 2'd1,
    HOLD = 2'd2,
    GOAL = 2'd3
  } tile_t;

  localparam logic [23:0] COL_SKY  = 24'h87ceeb;
  localparam logic [23:0] COL_ROCK = 24'h6b4f2a;
  localparam logic [23:0] COL_HOLD = 24'hc0c0c0;
  localparam logic [23:0] COL_GOAL = 24'hffd700;
  localparam logic [23:0] COL_GRID = 24'hffffff;

  localparam int unsigned XVGA_H_ACTIVE = 1024;
  localparam int unsigned XVGA_V_ACTIVE = 768;
  localparam int unsigned XVGA_H_TOTAL  = 1344;
  localparam int unsigned XVGA_V_TOTAL  = 806;

  function automatic logic [23:0] palette(input tile_t t);
    case (t)
      SKY:     palette = COL_SKY;
      ROCK:    palette = COL_ROCK;
      HOLD:    palette = COL_HOLD;
      GOAL:    palette = COL_GOAL;
      default: palette = COL_SKY;
    endcase
  endfunction

endpackage

// File: rtl/map_pixel_gen_delay_line.sv
// Fixed-depth shift register with a configurable reset pattern.
module delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= RESET_VAL;
    end else begin
      pipe[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/map_pixel_gen.sv
// Tile-map pixel generator: scroll-offset world lookup, map BRAM fetch, palette output.
module map_pixel_gen
  import map_pixel_gen_pkg::*;
#(
  parameter int unsigned TILE_LOG2  = 5,
  parameter int unsigned MAP_W_LOG2 = 6,
  parameter int unsigned MAP_H      = 256,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned ROM_LAT    = 2
) (
  input  logic              vclock,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank,
  input  logic [11:0]       screenx,
  input  logic [12:0]       screeny,
  input  logic              grid_en,
  output logic [ADDR_W-1:0] map_addr,
  input  logic [1:0]        map_data,
  output logic [23:0]       pixel,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out
);

  localparam int unsigned WX_W = 13;
  localparam int unsigned WY_W = 14;
  localparam int unsigned TY_W = ADDR_W - MAP_W_LOG2;

  logic            vsync_q;
  logic [11:0]     sx;
  logic [12:0]     sy;
  logic [WX_W-1:0] wx;
  logic [WY_W-1:0] wy;
  logic            oob;
  logic            on_grid;

  // Scroll is frozen for the frame; it only moves on a falling vsync.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      vsync_q <= 1'b1;
      sx      <= '0;
      sy      <= '0;
    end else begin
      vsync_q <= vsync;
      if (vsync_q && !vsync) begin
        sx <= screenx;
        sy <= screeny;
      end
    end
  end

  always_comb begin
    wx      = {sx[11], sx} + {2'b00, hcount};
    wy      = {sy[12], sy} + {4'b0000, vcount};
    oob     = wx[WX_W-1] | wy[WY_W-1]
            | ((wx >> TILE_LOG2) >= WX_W'(2 ** MAP_W_LOG2))
            | ((wy >> TILE_LOG2) >= WY_W'(MAP_H));
    on_grid = (wx[TILE_LOG2-1:0] == '0) | (wy[TILE_LOG2-1:0] == '0);
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      map_addr <= '0;
    end else if (!oob) begin
      map_addr <= {wy[TILE_LOG2 +: TY_W], wx[TILE_LOG2 +: MAP_W_LOG2]};
    end
  end

  // Flags and syncs ride alongside the address register plus the BRAM read.
  logic [4:0] dl_out;
  logic       d_oob, d_grid, d_hs, d_vs, d_blank;

  delay_line #(
    .WIDTH(5),
    .DEPTH(1 + ROM_LAT),
    .RESET_VAL(5'b00111)
  ) u_flags (
    .clk (vclock),
    .rst (reset),
    .din ({oob, on_grid, hsync, vsync, blank}),
    .dout(dl_out)
  );

  assign {d_oob, d_grid, d_hs, d_vs, d_blank} = dl_out;

  tile_t       tile;
  logic [23:0] colour;

  always_comb begin
    tile   = d_oob ? SKY : tile_t'(map_data);
    colour = palette(tile);
    if (grid_en && d_grid && !d_oob) colour = COL_GRID;
    if (d_blank) colour = '0;
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      pixel     <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      pixel     <= colour;
      hsync_out <= d_hs;
      vsync_out <= d_vs;
      blank_out <= d_blank;
    end
  end

endmodule

// File: tb/tb_map_pixel_gen.sv
// Self-checking bench for map_pixel_gen with a 2-cycle map BRAM model.
module tb_map_pixel_gen;
  import map_pixel_gen_pkg::*;

  logic        vclock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b1;
  logic [11:0] screenx = '0;
  logic [12:0] screeny = '0;
  logic        grid_en = 1'b0;
  logic [13:0] map_addr;
  logic [1:0]  map_data;
  logic [23:0] pixel;
  logic        hsync_out, vsync_out, blank_out;

  map_pixel_gen dut (
    .vclock   (vclock),
    .reset    (reset),
    .hcount   (hcount),
    .vcount   (vcount),
    .hsync    (hsync),
    .vsync    (vsync),
    .blank    (blank),
    .screenx  (screenx),
    .screeny  (screeny),
    .grid_en  (grid_en),
    .map_addr (map_addr),
    .map_data (map_data),
    .pixel    (pixel),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .blank_out(blank_out)
  );

  always #5 vclock = ~vclock;

  logic [1:0] mem [16384];
  logic [1:0] rd1;
  always @(posedge vclock) begin
    rd1      <= mem[map_addr];
    map_data <= rd1;
  end

  logic [26:0] obs;
  assign obs = {pixel, hsync_out, vsync_out, blank_out};

  localparam logic [26:0] IDLE_OUT = {24'h0, 3'b111};
  logic [23:0] pal [4] = '{COL_SKY, COL_ROCK, COL_HOLD, COL_GOAL};

  int checks = 0, errors = 0;
  int m_sx, m_sy, m_addr;
  bit m_prev_vs;
  logic [26:0] exp_q [$];

  // Reference: world coordinates in plain integers, 32-pixel tiles, 64x256 map.
  function automatic logic [26:0] predict(int hc, int vc, bit hs, bit vs, bit bl, output bit oob);
    int wx, wy;
    logic [23:0] p;
    wx  = m_sx + hc;
    wy  = m_sy + vc;
    oob = (wx < 0) || (wx >= 64 * 32) || (wy < 0) || (wy >= 256 * 32);
    if (bl) p = '0;
    else if (oob) p = COL_SKY;
    else if (grid_en && ((wx % 32) == 0 || (wy % 32) == 0)) p = COL_GRID;
    else p = pal[mem[(wy / 32) * 64 + wx / 32]];
    return {p, hs, vs, bl};
  endfunction

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_addr = 0; m_prev_vs = 1'b1;
    exp_q = '{IDLE_OUT, IDLE_OUT, IDLE_OUT};
  endtask

  task automatic tick(input int hc, input int vc, input bit hs, input bit vs, input bit bl,
                      output bit have, output logic [26:0] exp_out, output logic [13:0] exp_addr);
    bit oob;
    hcount = 11'(hc); vcount = 10'(vc); hsync = hs; vsync = vs; blank = bl;
    exp_q.push_back(predict(hc, vc, hs, vs, bl, oob));
    if (!oob) m_addr = ((m_sy + vc) / 32) * 64 + (m_sx + hc) / 32;
    if (m_prev_vs && !vs) begin
      m_sx = $signed(screenx);
      m_sy = $signed(screeny);
    end
    m_prev_vs = vs;
    @(posedge vclock); #1;
    have = (exp_q.size() >= 4);
    exp_out = have ? exp_q.pop_front() : 'x;
    exp_addr = 14'(m_addr);
  endtask

  task automatic latch_scroll(input logic [11:0] x, input logic [12:0] y);
    bit h; logic [26:0] e; logic [13:0] a;
    screenx = x; screeny = y;
    tick(0, 0, 1, 1, 1, h, e, a);
    tick(0, 0, 1, 0, 1, h, e, a);
    repeat (4) tick(0, 0, 1, 1, 1, h, e, a);
  endtask

  task automatic test_reset();
    bit have; logic [26:0] e; logic [13:0] ea;
    reset = 1'b1;
    repeat (3) @(posedge vclock);
    #1;
    checks++; if (obs !== IDLE_OUT) begin errors++; $display("FAIL reset_out got %h exp %h", obs, IDLE_OUT); end
    checks++; if (map_addr !== 14'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", map_addr); end
    reset = 1'b0; model_reset();
    for (int i = 0; i < 20; i++) begin
      tick(int'($urandom_range(0, 1023)), int'($urandom_range(0, 767)), 1, 1, 0, have, e, ea);
      if (have) begin checks++; if (obs !== e) begin errors++; $display("FAIL reset_run got %h exp %h", obs, e); end end
      checks++; if (map_addr !== ea) begin errors++; $display("FAIL reset_run_addr got %h exp %h", map_addr, ea); end
    end
    #3 reset = 1'b1;
    #1;
    checks++; if (obs !== IDLE_OUT) begin errors++; $display("FAIL midframe_reset got %h exp %h", obs, IDLE_OUT); end
    checks++; if (map_addr !== 14'd0) begin errors++; $display("FAIL midframe_addr got %h exp 0", map_addr); end
    @(posedge vclock); #1;
    reset = 1'b0; model_reset();
    for (int i = 0; i < 6; i++) begin
      tick(100 + i, 40, 1, 1, 0, have, e, ea);
      if (have) begin checks++; if (obs !== e) begin errors++; $display("FAIL refill got %h exp %h", obs, e); end end
      checks++; if (blank_out !== (i < 3)) begin errors++; $display("FAIL refill_blank i=%0d got %b", i, blank_out); end
    end
  endtask

  task automatic test_scroll_latch();
    bit have; logic [26:0] e; logic [13:0] ea;
    int hl [5] = '{0, 0, 33, 34, 35};
    logic [13:0] want [5] = '{14'd3, 14'd3, 14'd4, 14'd4, 14'd4};
    latch_scroll(12'd100, 13'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) screenx = 12'd500;
      tick(hl[i], 0, 1, 1, 0, have, e, ea);
      if (have) begin checks++; if (obs !== e) begin errors++; $display("FAIL scroll_pix got %h exp %h", obs, e); end end
      checks++; if (map_addr !== want[i]) begin errors++; $display("FAIL scroll_addr i=%0d got %0d exp %0d", i, map_addr, want[i]); end
      checks++; if (map_addr !== ea) begin errors++; $display("FAIL scroll_model_addr got %0d exp %0d", map_addr, ea); end
    end
    latch_scroll(12'd500, 13'd0);
    tick(0, 0, 1, 1, 0, have, e, ea);
    checks++; if (map_addr !== 14'd15) begin errors++; $display("FAIL scroll_relatch got %0d exp 15", map_addr); end
  endtask

  task automatic test_negative_scroll();
    bit have; logic [26:0] e; logic [13:0] ea;
    int hl [9] = '{10, 11, 12, 13, 39, 40, 41, 42, 43};
    latch_scroll(12'hfd8, 13'd0);
    for (int i = 0; i < 9; i++) begin
      tick(hl[i], 100, 1, 1, 0, have, e, ea);
      if (have) begin checks++; if (obs !== e) begin errors++; $display("FAIL neg_pix h=%0d got %h exp %h", hl[i], obs, e); end end
      checks++; if (map_addr !== ea) begin errors++; $display("FAIL neg_addr got %0d exp %0d", map_addr, ea); end
      if (i == 3) begin checks++; if (pixel !== COL_SKY) begin errors++; $display("FAIL neg_sky got %h exp %h", pixel, COL_SKY); end end
      if (i == 5) begin checks++; if (map_addr !== 14'd192) begin errors++; $display("FAIL neg_tx0 got %0d exp 192", map_addr); end end
      if (i == 8) begin checks++; if (pixel !== pal[mem[192]]) begin errors++; $display("FAIL neg_bram got %h exp %h", pixel, pal[mem[192]]); end end
    end
  endtask

  task automatic test_right_edge();
    bit have; logic [26:0] e; logic [13:0] ea;
    int hl [7] = '{1046, 1047, 1048, 1049, 1050, 1051, 1052};
    latch_scroll(12'd1000, 13'd0);
    for (int i = 0; i < 7; i++) begin
      tick(hl[i], 0, 1, 1, 0, have, e, ea);
      if (have) begin checks++; if (obs !== e) begin errors++; $display("FAIL edge_pix h=%0d got %h exp %h", hl[i], obs, e); end end
      if (i >= 1) begin checks++; if (map_addr !== 14'd63) begin errors++; $display("FAIL edge_addr h=%0d got %0d exp 63", hl[i], map_addr); end end
      if (i == 5) begin checks++; if (pixel !== COL_SKY) begin errors++; $display("FAIL edge_oob got %h exp %h", pixel, COL_SKY); end end
    end
  endtask

  task automatic test_grid();
    bit have; logic [26:0] e; logic [13:0] ea;
    latch_scroll(12'd0, 13'd0);
    for (int pass = 0; pass < 2; pass++) begin
      grid_en = (pass == 0);
      for (int i = 0; i < 4; i++) begin
        tick(32 + i, 5, 1, 1, 0, have, e, ea);
        if (have) begin checks++; if (obs !== e) begin errors++; $display("FAIL grid_pix got %h exp %h", obs, e); end end
      end
      checks++;
      if (pixel !== (pass == 0 ? COL_GRID : COL_ROCK)) begin
        errors++; $display("FAIL grid_colour pass=%0d got %h", pass, pixel);
      end
      for (int i = 0; i < 4; i++) begin
        tick(0, 0, 1, 1, 1, have, e, ea);
        if (have) begin checks++; if (obs !== e) begin errors++; $display("FAIL grid_drain got %h exp %h", obs, e); end end
      end
    end
  endtask

  task automatic test_blanking();
    bit have; logic [26:0] e; logic [13:0] ea;
    bit hs_a [16], vs_a [16], bl_a [16];
    screenx = '0; screeny = '0;
    for (int i = 0; i < 16; i++) begin
      hs_a[i] = 1'($urandom); vs_a[i] = 1'($urandom); bl_a[i] = (i < 4) ? 1'b1 : 1'($urandom);
      tick(70, 10, hs_a[i], vs_a[i], bl_a[i], have, e, ea);
      if (have) begin checks++; if (obs !== e) begin errors++; $display("FAIL blank_pix got %h exp %h", obs, e); end end
      if (i >= 3) begin
        checks++;
        if ({hsync_out, vsync_out, blank_out} !== {hs_a[i-3], vs_a[i-3], bl_a[i-3]}) begin
          errors++; $display("FAIL blank_sync i=%0d got %b%b%b exp %b%b%b", i, hsync_out, vsync_out, blank_out, hs_a[i-3], vs_a[i-3], bl_a[i-3]);
        end
        checks++;
        if (pixel !== (bl_a[i-3] ? 24'h0 : COL_HOLD)) begin
          errors++; $display("FAIL blank_colour i=%0d got %h", i, pixel);
        end
      end
    end
    latch_scroll(12'd0, 13'd0);
  endtask

  task automatic test_random();
    bit have; logic [26:0] e; logic [13:0] ea;
    bit vs, bl;
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 4; i++) begin
        tick(0, 0, 1, 1, 1, have, e, ea);
        if (have) begin checks++; if (obs !== e) begin errors++; $display("FAIL rand_drain got %h exp %h", obs, e); end end
      end
      grid_en = 1'($urandom);
      for (int j = 0; j < 60; j++) begin
        screenx = 12'($urandom); screeny = 13'($urandom);
        vs = (j != 30);
        bl = (j == 30) ? 1'b1 : ($urandom_range(0, 7) == 0);
        tick(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'($urandom), vs, bl, have, e, ea);
        if (have) begin checks++; if (obs !== e) begin errors++; $display("FAIL rand_pix got %h exp %h", obs, e); end end
        checks++; if (map_addr !== ea) begin errors++; $display("FAIL rand_addr got %0d exp %0d", map_addr, ea); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 2'($urandom_range(0, 3));
    mem[1] = ROCK;
    mem[2] = HOLD;
    test_reset();
    test_scroll_latch();
    test_negative_scroll();
    test_right_edge();
    test_grid();
    test_blanking();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
